// File: rtl/sd_spi_pkg.sv
// Shared constants for the SPI-mode SD card responder: command indices,
// data tokens, R1 flag bits, OCR value, CRC bytes checked during init and
// the responder FSM state encoding.
package sd_spi_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD16 = 6'd16;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD24 = 6'd24;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;
  localparam logic [5:0] CMD59 = 6'd59;

  localparam logic [7:0] TOKEN_START   = 8'hFE;
  localparam logic [7:0] TOKEN_DATA_OK = 8'h05;

  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_ILLEGAL = 8'h04;
  localparam logic [7:0] R1_CRC     = 8'h08;
  localparam logic [7:0] R1_PARAM   = 8'h40;

  localparam logic [31:0] OCR_VALUE = 32'hC0FF8000;

  // Only the two commands a host must send before it can disable CRC are checked.
  localparam logic [7:0] CRC_CMD0 = 8'h95;
  localparam logic [7:0] CRC_CMD8 = 8'h87;

  typedef enum logic [3:0] {
    HUNT, CMD_RX, NCR, RESP, RD_DLY, RD_TOKEN, RD_DATA, RD_CRC,
    WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
  } state_t;

endpackage

// File: rtl/sd_spi_card_model_if.sv
// SPI link between an SD host (master) and the card model (slave), plus the
// card's decoded-command status outputs.
// master drives spi_clk/spi_cs_n/spi_mosi; slave drives miso and status.
interface sd_spi_card_model_if;
  logic        spi_clk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        card_idle;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  modport master (
    output spi_clk, spi_cs_n, spi_mosi,
    input  spi_miso, card_idle, cmd_valid, cmd_index, cmd_arg
  );

  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi,
    output spi_miso, card_idle, cmd_valid, cmd_index, cmd_arg
  );
endinterface

// File: rtl/sd_spi_byte_shifter.sv
// Oversampled SPI mode-0 byte shifter: synchronizes spi_clk/cs_n/mosi, shifts
// mosi in on rising edges and miso out on falling edges.
// Ports: raw SPI inputs, tx_byte (sampled on tx_load), spi_miso, cs_idle,
// rx_vld/rx_dat (8th rising edge of a byte), tx_load (8th falling edge).
module sd_spi_byte_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  input  logic [7:0] tx_byte,
  output logic       spi_miso,
  output logic       cs_idle,
  output logic       rx_vld,
  output logic [7:0] rx_dat,
  output logic       tx_load
);

  // Bit order in the sync vectors: {spi_clk, spi_cs_n, spi_mosi}.
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [2:0] rx_cnt_q, rx_cnt_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [2:0] tx_cnt_q, tx_cnt_d;
  logic       sclk_rise, sclk_fall, mosi_s;

  assign cs_idle   = sync2_q[1];
  assign mosi_s    = sync2_q[0];
  assign sclk_rise = ~cs_idle & sync2_q[2] & ~sclk_prev_q;
  assign sclk_fall = ~cs_idle & ~sync2_q[2] & sclk_prev_q;
  assign rx_vld    = sclk_rise & (rx_cnt_q == 3'd7);
  assign rx_dat    = {rx_sh_q, mosi_s};
  assign tx_load   = sclk_fall & (tx_cnt_q == 3'd7);
  assign spi_miso  = cs_idle | tx_sh_q[7];

  always_comb begin
    sync1_d     = {spi_clk, spi_cs_n, spi_mosi};
    sync2_d     = sync1_q;
    sclk_prev_d = sync2_q[2];
    rx_sh_d     = rx_sh_q;
    rx_cnt_d    = rx_cnt_q;
    tx_sh_d     = tx_sh_q;
    tx_cnt_d    = tx_cnt_q;
    if (cs_idle) begin
      // Deselected: realign to a byte boundary and idle the line high.
      rx_cnt_d = 3'd0;
      tx_cnt_d = 3'd0;
      tx_sh_d  = 8'hFF;
    end else begin
      if (sclk_rise) begin
        rx_sh_d  = rx_dat[6:0];
        rx_cnt_d = rx_cnt_q + 3'd1;
      end
      if (sclk_fall) begin
        tx_sh_d  = (tx_cnt_q == 3'd7) ? tx_byte : {tx_sh_q[6:0], 1'b1};
        tx_cnt_d = tx_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 3'b010;
      sync2_q     <= 3'b010;
      sclk_prev_q <= 1'b0;
      rx_sh_q     <= '0;
      rx_cnt_q    <= '0;
      tx_sh_q     <= 8'hFF;
      tx_cnt_q    <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sclk_prev_q <= sclk_prev_d;
      rx_sh_q     <= rx_sh_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_sh_q     <= tx_sh_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

endmodule

// File: rtl/sd_spi_card_model.sv
// SPI-mode SD card responder: decodes 6-byte commands, answers R1/R3/R7 and
// serves single-block CMD17 reads / CMD24 writes from an internal RAM.
// Ports: clk, rst_n, bus (slave modport: SPI pins, card_idle, cmd_valid/index/arg).
module sd_spi_card_model
  import sd_spi_pkg::*;
#(
  parameter int BLOCK_BYTES      = 64,
  parameter int NUM_BLOCKS       = 4,
  parameter int INIT_IDLE_POLLS  = 2,
  parameter int NCR_BYTES        = 1,
  parameter int READ_DELAY_BYTES = 1,
  parameter int BUSY_BYTES       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sd_spi_card_model_if.slave   bus
);

  localparam int CNT_W  = $clog2(BLOCK_BYTES + 2);
  localparam int ADDR_W = (NUM_BLOCKS * BLOCK_BYTES > 1) ? $clog2(NUM_BLOCKS * BLOCK_BYTES) : 1;
  localparam int BLK_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int POLL_W = (INIT_IDLE_POLLS > 0) ? $clog2(INIT_IDLE_POLLS + 1) : 1;

  logic              cs_idle, rx_vld, tx_load, mem_we;
  logic [7:0]        rx_dat, tx_byte;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_q [NUM_BLOCKS*BLOCK_BYTES];

  state_t            state_q, state_d, post_q, post_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [37:0]       frame_q, frame_d;
  logic [39:0]       resp_q, resp_d;
  logic [2:0]        resp_len_q, resp_len_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic              card_idle_q, card_idle_d, crc_en_q, crc_en_d, app_cmd_q, app_cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [5:0]        cmd_index_q, cmd_index_d;
  logic [31:0]       cmd_arg_q, cmd_arg_d;

  // Completed frame as seen on the cycle its CRC byte arrives.
  logic [45:0] full;
  logic [5:0]  f_idx;
  logic [31:0] f_arg;
  logic [7:0]  f_crc, r1;
  logic        crc_bad;

  assign full    = {frame_q, rx_dat};
  assign f_idx   = full[45:40];
  assign f_arg   = full[39:8];
  assign f_crc   = full[7:0];
  assign r1      = {7'b0, card_idle_q};
  assign crc_bad = crc_en_q && (((f_idx == CMD0) && (f_crc != CRC_CMD0)) ||
                                ((f_idx == CMD8) && (f_crc != CRC_CMD8)));
  assign mem_addr = ADDR_W'(blk_q) * ADDR_W'(BLOCK_BYTES) + ADDR_W'(cnt_q);

  assign bus.card_idle = card_idle_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_index = cmd_index_q;
  assign bus.cmd_arg   = cmd_arg_q;

  sd_spi_byte_shifter u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi_clk  (bus.spi_clk),
    .spi_cs_n (bus.spi_cs_n),
    .spi_mosi (bus.spi_mosi),
    .tx_byte  (tx_byte),
    .spi_miso (bus.spi_miso),
    .cs_idle  (cs_idle),
    .rx_vld   (rx_vld),
    .rx_dat   (rx_dat),
    .tx_load  (tx_load)
  );

  // Input phases advance on rx_vld, output phases on tx_load; tx_byte is the
  // byte that the next tx_load will put on the wire.
  always_comb begin
    state_d = state_q;   post_d = post_q;     cnt_d = cnt_q;
    frame_d = frame_q;   resp_d = resp_q;     resp_len_d = resp_len_q;
    blk_d = blk_q;       poll_d = poll_q;     card_idle_d = card_idle_q;
    crc_en_d = crc_en_q; app_cmd_d = app_cmd_q;
    cmd_valid_d = 1'b0;  cmd_index_d = cmd_index_q; cmd_arg_d = cmd_arg_q;
    tx_byte = 8'hFF;     mem_we = 1'b0;
    if (cs_idle) begin
      state_d = HUNT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        HUNT: if (rx_vld && rx_dat[7:6] == 2'b01) begin
          frame_d = {32'h0, rx_dat[5:0]};
          cnt_d   = '0;
          state_d = CMD_RX;
        end
        CMD_RX: if (rx_vld) begin
          frame_d = full[37:0];
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(4)) begin
            cmd_valid_d = 1'b1;
            cmd_index_d = f_idx;
            cmd_arg_d   = f_arg;
            app_cmd_d   = 1'b0;
            post_d      = HUNT;
            resp_len_d  = 3'd1;
            resp_d      = {r1 | R1_ILLEGAL, 32'hFFFF_FFFF};
            cnt_d       = '0;
            state_d     = (NCR_BYTES == 0) ? RESP : NCR;
            if (crc_bad) begin
              resp_d[39:32] = r1 | R1_CRC;
            end else begin
              case (f_idx)
                CMD0: begin
                  resp_d[39:32] = R1_IDLE;
                  card_idle_d   = 1'b1;
                  poll_d        = '0;
                end
                CMD8: begin
                  resp_d     = {R1_IDLE, 16'h0000, 4'h0, f_arg[11:8], f_arg[7:0]};
                  resp_len_d = 3'd5;
                end
                CMD59: begin
                  resp_d[39:32] = r1;
                  crc_en_d      = f_arg[0];
                end
                CMD55: begin
                  resp_d[39:32] = r1;
                  app_cmd_d     = 1'b1;
                end
                CMD41: if (app_cmd_q) begin
                  if (poll_q < POLL_W'(INIT_IDLE_POLLS)) begin
                    resp_d[39:32] = R1_IDLE;
                    poll_d        = poll_q + POLL_W'(1);
                  end else begin
                    resp_d[39:32] = 8'h00;
                    card_idle_d   = 1'b0;
                  end
                end
                CMD58: begin
                  resp_d     = {r1, OCR_VALUE};
                  resp_len_d = 3'd5;
                end
                CMD16: resp_d[39:32] = (f_arg == 32'(BLOCK_BYTES)) ? 8'h00 : (r1 | R1_PARAM);
                CMD17, CMD24: begin
                  if (card_idle_q) begin
                    resp_d[39:32] = R1_ILLEGAL | R1_IDLE;
                  end else if (f_arg >= 32'(NUM_BLOCKS)) begin
                    resp_d[39:32] = R1_PARAM;
                  end else begin
                    resp_d[39:32] = 8'h00;
                    blk_d         = f_arg[BLK_W-1:0];
                    if (f_idx == CMD24)            post_d = WR_TOKEN;
                    else if (READ_DELAY_BYTES > 0) post_d = RD_DLY;
                    else                           post_d = RD_TOKEN;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        NCR: if (tx_load) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NCR_BYTES - 1)) begin state_d = RESP; cnt_d = '0; end
        end
        RESP: begin
          tx_byte = resp_q[39:32];
          if (tx_load) begin
            resp_d = {resp_q[31:0], 8'hFF};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(resp_len_q) - CNT_W'(1)) begin state_d = post_q; cnt_d = '0; end
          end
        end
        RD_DLY: if (tx_load) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(READ_DELAY_BYTES - 1)) begin state_d = RD_TOKEN; cnt_d = '0; end
        end
        RD_TOKEN: begin
          tx_byte = TOKEN_START;
          if (tx_load) begin state_d = RD_DATA; cnt_d = '0; end
        end
        RD_DATA: begin
          tx_byte = mem_q[mem_addr];
          if (tx_load) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BLOCK_BYTES - 1)) begin state_d = RD_CRC; cnt_d = '0; end
          end
        end
        RD_CRC: if (tx_load) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin state_d = HUNT; cnt_d = '0; end
        end
        WR_TOKEN: if (rx_vld) begin
          if (rx_dat == TOKEN_START) begin state_d = WR_DATA; cnt_d = '0; end
          else if (rx_dat != 8'hFF)  state_d = HUNT;
        end
        WR_DATA: if (rx_vld) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BLOCK_BYTES - 1)) begin state_d = WR_CRC; cnt_d = '0; end
        end
        WR_CRC: if (rx_vld) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin state_d = WR_RESP; cnt_d = '0; end
        end
        WR_RESP: begin
          tx_byte = TOKEN_DATA_OK;
          if (tx_load) begin state_d = (BUSY_BYTES > 0) ? WR_BUSY : HUNT; cnt_d = '0; end
        end
        WR_BUSY: begin
          tx_byte = 8'h00;
          if (tx_load) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BUSY_BYTES - 1)) begin state_d = HUNT; cnt_d = '0; end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;  post_q <= HUNT;   cnt_q <= '0;
      frame_q <= '0;    resp_q <= '1;     resp_len_q <= 3'd1;
      blk_q <= '0;      poll_q <= '0;     card_idle_q <= 1'b1;
      crc_en_q <= 1'b1; app_cmd_q <= 1'b0;
      cmd_valid_q <= 1'b0; cmd_index_q <= '0; cmd_arg_q <= '0;
    end else begin
      state_q <= state_d;   post_q <= post_d;   cnt_q <= cnt_d;
      frame_q <= frame_d;   resp_q <= resp_d;   resp_len_q <= resp_len_d;
      blk_q <= blk_d;       poll_q <= poll_d;   card_idle_q <= card_idle_d;
      crc_en_q <= crc_en_d; app_cmd_q <= app_cmd_d;
      cmd_valid_q <= cmd_valid_d; cmd_index_q <= cmd_index_d; cmd_arg_q <= cmd_arg_d;
    end
  end

  // Block RAM keeps its contents across reset and CS aborts.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= rx_dat;
  end

endmodule

// File: tb/tb_sd_spi_card_model.sv
module tb_sd_spi_card_model;
  import sd_spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;
  logic [7:0] rbuf [0:79];

  sd_spi_card_model_if bus();

  sd_spi_card_model dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.cmd_valid === 1'b1) valid_cnt++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 900000", $time);
    $fatal(1, "watchdog");
  end

  // One SPI mode-0 byte; every edge lands on a clk negedge, half period 5 clk.
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bus.spi_mosi = tx[i];
      #50;
      rx[i] = bus.spi_miso;
      bus.spi_clk = 1'b1;
      #50;
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    logic [7:0] d;
    xfer({2'b01, idx}, d);
    xfer(arg[31:24], d); xfer(arg[23:16], d); xfer(arg[15:8], d); xfer(arg[7:0], d);
    xfer(crc, d);
  endtask

  task automatic read_bytes(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      xfer(8'hFF, b);
      rbuf[i] = b;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    #100;
  endtask

  task automatic cs_high();
    #100;
    bus.spi_cs_n = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.spi_miso !== 1'b1) begin errors++; $display("FAIL reset_miso got %b want 1", bus.spi_miso); end
    checks++; if (bus.card_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", bus.card_idle); end
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.cmd_valid); end
    checks++; if (bus.cmd_index !== 6'd0) begin errors++; $display("FAIL reset_index got %0d want 0", bus.cmd_index); end
    checks++; if (bus.cmd_arg !== 32'd0) begin errors++; $display("FAIL reset_arg got %h want 0", bus.cmd_arg); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dut.state_q !== HUNT) begin errors++; $display("FAIL reset_state got %0d want HUNT", dut.state_q); end
  endtask

  task automatic test_cmd0();
    logic [15:0] exp;
    int v0;
    exp = 16'hFF01;
    v0 = valid_cnt;
    cs_low(); send_cmd(CMD0, 32'h0, 8'h95); read_bytes(2); cs_high();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rbuf[i] !== exp[8*(1-i) +: 8]) begin errors++; $display("FAIL cmd0 byte %0d got %02h want %02h", i, rbuf[i], exp[8*(1-i) +: 8]); end
    end
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL cmd0_valid pulses got %0d want 1", valid_cnt - v0); end
    checks++; if (bus.cmd_index !== 6'd0) begin errors++; $display("FAIL cmd0_index got %0d want 0", bus.cmd_index); end
  endtask

  task automatic test_cmd8();
    logic [47:0] exp;
    exp = 48'hFF_01_00_00_01_AA;
    cs_low(); send_cmd(CMD8, 32'h0000_01AA, 8'h87); read_bytes(6); cs_high();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rbuf[i] !== exp[8*(5-i) +: 8]) begin errors++; $display("FAIL cmd8 byte %0d got %02h want %02h", i, rbuf[i], exp[8*(5-i) +: 8]); end
    end
    checks++; if (bus.cmd_index !== 6'd8) begin errors++; $display("FAIL cmd8_index got %0d want 8", bus.cmd_index); end
    checks++; if (bus.cmd_arg !== 32'h1AA) begin errors++; $display("FAIL cmd8_arg got %h want 000001aa", bus.cmd_arg); end
  endtask

  task automatic test_crc_error();
    cs_low(); send_cmd(CMD0, 32'h0, 8'h00); read_bytes(2); cs_high();
    checks++; if (rbuf[1] !== 8'h09) begin errors++; $display("FAIL crc_error got %02h want 09", rbuf[1]); end
  endtask

  task automatic test_read_before_init();
    logic [31:0] exp;
    exp = 32'hFF_05_FF_FF;
    cs_low(); send_cmd(CMD17, 32'd2, 8'hFF); read_bytes(4); cs_high();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== exp[8*(3-i) +: 8]) begin errors++; $display("FAIL read_idle byte %0d got %02h want %02h", i, rbuf[i], exp[8*(3-i) +: 8]); end
    end
  endtask

  task automatic test_crc_disable();
    cs_low(); send_cmd(CMD59, 32'h0, 8'h01); read_bytes(2); cs_high();
    checks++; if (rbuf[1] !== 8'h01) begin errors++; $display("FAIL cmd59 got %02h want 01", rbuf[1]); end
    cs_low(); send_cmd(CMD0, 32'h0, 8'h00); read_bytes(2); cs_high();
    checks++; if (rbuf[1] !== 8'h01) begin errors++; $display("FAIL crc_off_cmd0 got %02h want 01", rbuf[1]); end
  endtask

  task automatic test_init();
    logic [7:0] exp41;
    for (int k = 0; k < 3; k++) begin
      exp41 = (k < 2) ? 8'h01 : 8'h00;
      cs_low(); send_cmd(CMD55, 32'h0, 8'hFF); read_bytes(2); cs_high();
      checks++; if (rbuf[1] !== 8'h01) begin errors++; $display("FAIL cmd55 pass %0d got %02h want 01", k, rbuf[1]); end
      cs_low(); send_cmd(CMD41, 32'h4000_0000, 8'hFF); read_bytes(2); cs_high();
      checks++; if (rbuf[1] !== exp41) begin errors++; $display("FAIL acmd41 pass %0d got %02h want %02h", k, rbuf[1], exp41); end
      checks++; if (bus.card_idle !== (k < 2)) begin errors++; $display("FAIL card_idle pass %0d got %b want %b", k, bus.card_idle, (k < 2)); end
    end
    cs_low(); send_cmd(CMD41, 32'h4000_0000, 8'hFF); read_bytes(2); cs_high();
    checks++; if (rbuf[1] !== 8'h04) begin errors++; $display("FAIL cmd41_no_app got %02h want 04", rbuf[1]); end
  endtask

  task automatic test_cmd58();
    logic [47:0] exp;
    exp = 48'hFF_00_C0_FF_80_00;
    cs_low(); send_cmd(CMD58, 32'h0, 8'hFF); read_bytes(6); cs_high();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rbuf[i] !== exp[8*(5-i) +: 8]) begin errors++; $display("FAIL cmd58 byte %0d got %02h want %02h", i, rbuf[i], exp[8*(5-i) +: 8]); end
    end
  endtask

  task automatic test_cmd16();
    cs_low(); send_cmd(CMD16, 32'h40, 8'hFF); read_bytes(2); cs_high();
    checks++; if (rbuf[1] !== 8'h00) begin errors++; $display("FAIL cmd16_ok got %02h want 00", rbuf[1]); end
    cs_low(); send_cmd(CMD16, 32'h200, 8'hFF); read_bytes(2); cs_high();
    checks++; if (rbuf[1] !== 8'h40) begin errors++; $display("FAIL cmd16_bad got %02h want 40", rbuf[1]); end
  endtask

  task automatic test_write();
    logic [7:0] d, exp;
    cs_low(); send_cmd(CMD24, 32'd2, 8'hFF); read_bytes(3);
    checks++; if (rbuf[1] !== 8'h00) begin errors++; $display("FAIL write_r1 got %02h want 00", rbuf[1]); end
    xfer(8'hFE, d);
    for (int i = 0; i < 64; i++) xfer(8'hA0 + 8'(i), d);
    xfer(8'hFF, d); xfer(8'hFF, d);
    read_bytes(10); cs_high();
    for (int i = 0; i < 10; i++) begin
      exp = (i == 0) ? 8'h05 : (i == 9) ? 8'hFF : 8'h00;
      checks++;
      if (rbuf[i] !== exp) begin errors++; $display("FAIL write_resp byte %0d got %02h want %02h", i, rbuf[i], exp); end
    end
  endtask

  // Expected block 2: first n_new bytes 0x10+j from the aborted write, rest 0xA0+j.
  task automatic test_read_block(input int n_new);
    logic [7:0] exp;
    cs_low(); send_cmd(CMD17, 32'd2, 8'hFF); read_bytes(70); cs_high();
    for (int i = 0; i < 70; i++) begin
      if (i == 1)       exp = 8'h00;
      else if (i == 3)  exp = 8'hFE;
      else if (i < 4 || i >= 68) exp = 8'hFF;
      else if (i - 4 < n_new) exp = 8'h10 + 8'(i - 4);
      else              exp = 8'hA0 + 8'(i - 4);
      checks++;
      if (rbuf[i] !== exp) begin errors++; $display("FAIL read_blk new=%0d byte %0d got %02h want %02h", n_new, i, rbuf[i], exp); end
    end
  endtask

  task automatic test_read_range();
    logic [31:0] exp;
    exp = 32'hFF_40_FF_FF;
    cs_low(); send_cmd(CMD17, 32'd4, 8'hFF); read_bytes(4); cs_high();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== exp[8*(3-i) +: 8]) begin errors++; $display("FAIL read_range byte %0d got %02h want %02h", i, rbuf[i], exp[8*(3-i) +: 8]); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    cs_low(); send_cmd(CMD24, 32'd2, 8'hFF); read_bytes(3);
    checks++; if (rbuf[1] !== 8'h00) begin errors++; $display("FAIL abort_r1 got %02h want 00", rbuf[1]); end
    xfer(8'hFE, d);
    for (int i = 0; i < 10; i++) xfer(8'h10 + 8'(i), d);
    cs_high();
    checks++; if (dut.state_q !== HUNT) begin errors++; $display("FAIL abort_state got %0d want HUNT", dut.state_q); end
    checks++; if (bus.card_idle !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", bus.card_idle); end
    checks++; if (bus.spi_miso !== 1'b1) begin errors++; $display("FAIL abort_miso got %b want 1", bus.spi_miso); end
  endtask

  initial begin
    bus.spi_clk  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b1;
    test_reset();
    test_cmd0();
    test_cmd8();
    test_crc_error();
    test_read_before_init();
    test_crc_disable();
    test_init();
    test_cmd58();
    test_cmd16();
    test_write();
    test_read_block(0);
    test_read_range();
    test_abort();
    test_read_block(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_spi_card_model.md
Name: sd_spi_card_model

Overview:
- Synthesizable SPI-mode SD card responder: the device end of the SD_Controller host link.
- Oversamples the host's SPI mode-0 bus on the system clock, decodes 6-byte commands, and returns R1/R3/R7 responses.
- Serves single-block reads (CMD17) and writes (CMD24) from a small internal block RAM.
- Used as the card stand-in for system-level simulation and FPGA loopback of SD_Controller.

Parameters:
BLOCK_BYTES, 64, bytes per block; CMD16 must request exactly this value
NUM_BLOCKS, 4, blocks in internal RAM; CMD17/CMD24 arg is the block index (SDHC-style)
INIT_IDLE_POLLS, 2, number of ACMD41 calls answered 0x01 before 0x00
NCR_BYTES, 1, 0xFF fill bytes between a command's CRC byte and its response
READ_DELAY_BYTES, 1, 0xFF bytes between the CMD17 R1 and the 0xFE token
BUSY_BYTES, 8, 0x00 busy bytes after the write data response

Ports:
clk  in  1  system clock; spi_clk high and low phases each >= 3 clk
rst_n  in  1  asynchronous active-low reset
spi_clk  in  1  host SPI clock, mode 0
spi_cs_n  in  1  host chip select, active low
spi_mosi  in  1  host-to-card data, MSB first
spi_miso  out  1  card-to-host data, MSB first
card_idle  out  1  R1 idle bit (1 until ACMD41 completes)
cmd_valid  out  1  one-clk pulse when a complete command frame is decoded
cmd_index  out  6  index of the last decoded command
cmd_arg  out  32  argument of the last decoded command

Behaviour:
- Reset values: spi_miso=1, card_idle=1, cmd_valid=0, cmd_index=0, cmd_arg=0, crc_en=1, app_cmd=0, idle-poll counter=0, FSM=HUNT. RAM contents are not reset.
- spi_clk, spi_cs_n and spi_mosi each pass through a 2-flop synchronizer.
- A rising spi_clk edge samples mosi. A falling edge shifts tx; spi_miso = tx_sh[7] while CS is low, and 1 while CS is high.
- After every 8th falling edge the next tx byte loads. The default tx byte is 0xFF.
- CS high at any time: bit counter clears, FSM returns to HUNT, and any read/write in progress is aborted. Write bytes already stored stay in RAM. Init state (card_idle, crc_en) is kept.
- FSM states: HUNT, CMD_RX, NCR, RESP, RD_DLY, RD_TOKEN, RD_DATA, RD_CRC, WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY.
- HUNT: a received byte with bits[7:6]=01 starts a frame. CMD_RX collects 5 more bytes, then pulses cmd_valid for one clk, then goes to NCR.
- CRC check: applies only to CMD0 (byte 0x95) and CMD8 (byte 0x87) while crc_en=1. A mismatch answers R1=0x08|idle.
- CMD0 -> 0x01; sets card_idle=1 and clears the poll counter.
- CMD8 -> R7: 0x01, 0x00, 0x00, arg[11:8], arg[7:0].
- CMD59 -> R1; crc_en=arg[0].
- CMD55 -> R1; sets app_cmd. app_cmd clears after the next command.
- ACMD41 (CMD41 with app_cmd=1) -> 0x01 while the poll counter < INIT_IDLE_POLLS (counter then increments), else 0x00 and card_idle=0.
- CMD58 -> R3: R1, then OCR 0xC0FF8000.
- CMD16 -> 0x00 if arg==BLOCK_BYTES, else 0x40|idle.
- CMD17/CMD24 while card_idle=1 -> 0x05. Arg >= NUM_BLOCKS -> 0x40, no data phase. Any other command -> 0x04|idle.
- Read: R1 0x00, then READ_DELAY_BYTES x 0xFF, then 0xFE, then BLOCK_BYTES RAM bytes in ascending address order, then 2 CRC bytes 0xFF. Returns to HUNT.
- Write: R1 0x00; WR_TOKEN skips 0xFF bytes until 0xFE. Any other byte returns to HUNT. Then BLOCK_BYTES bytes are stored to RAM as each completes, then 2 CRC bytes are ignored. Data response 0x05 follows, then BUSY_BYTES x 0x00, then 0xFF; returns to HUNT.
- Bytes received during a response or read phase are ignored. No new command is decoded until the FSM is back in HUNT.
- Byte counter width is clog2(BLOCK_BYTES+2). RAM address = block*BLOCK_BYTES + byte.

Decomposition:
- Package sd_spi_pkg holds:
  - command index constants (CMD0/8/16/17/24/41/55/58/59);
  - tokens 0xFE and 0x05;
  - R1 bit masks (idle 0x01, illegal 0x04, crc 0x08, param 0x40);
  - OCR constant;
  - state enum.
- Sub-module sd_spi_byte_shifter holds the synchronizers, edge detection, rx/tx 8-bit shift registers and byte_done/load strobes.

Test Plan:
- CS low, send 40 00 00 00 00 95 -> after one 0xFF fill, MISO byte 0x01; cmd_valid pulses with cmd_index=0.
- CMD8 48 00 00 01 AA 87 -> 01 00 00 01 AA.
- CMD0 with CRC 0x00 -> 0x09.
- CMD59 arg 0 -> 0x01; then CMD0 with bad CRC -> 0x01.
- CMD55+ACMD41 three times -> 0x01, 0x01, 0x00; card_idle falls after the third. CMD58 -> 00 C0 FF 80 00. CMD16 arg 0x40 -> 0x00; arg 0x200 -> 0x40.
- CMD24 block 2, then 3 x 0xFF, 0xFE, bytes 0xA0..0xDF, CRC FF FF -> 0x05, 8 x 0x00, then 0xFF. CMD17 block 2 -> 0x00, 0xFF, 0xFE, 0xA0..0xDF, FF FF.
- CMD17 block 4 -> 0x40 with no token.
- CMD17 before init -> 0x05.
- CS raised after 10 bytes of a write -> next CMD17 returns those 10 new bytes followed by the old contents; FSM is in HUNT.
